// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Fetch-stage branch predictor. A direct-mapped branch target
//               buffer (valid/tag/target/is_jump) sits beside a table of
//               2-bit saturating direction counters. Lookup is combinational
//               from registered state, so a prediction costs zero cycles.
//               Resolved control transfers from decode train both tables.
//               Decode also reports mispredictions and keeps a saturating
//               count of them.
//
//               Optional feature, macro BP_GSHARE_EN:
//                 defined   - the counter table is indexed by the PC index
//                             XOR a global history register. The BTB is
//                             still indexed by PC alone.
//                 undefined - the counter table is indexed by the PC index
//                             alone, and no history register exists.
//
// Ports       : clk                in  clock, all state updates on rising edge
//               rst_n              in  asynchronous active-low reset
//               PC_F               in  fetch PC to predict
//               pred_taken_F       out predict a redirect at fetch
//               pred_target_F      out predicted target (PC_F+4 on BTB miss)
//               upd_valid_D        in  a resolved control transfer is present
//               upd_PC_D           in  PC of the resolved instruction
//               upd_is_branch_D    in  1 = conditional branch, 0 = JAL/JALR
//               upd_taken_D        in  resolved direction
//               upd_target_D       in  resolved target
//               upd_pred_taken_D   in  direction predicted at fetch
//               upd_pred_target_D  in  target predicted at fetch
//               mispredict_D       out resolved outcome differs from prediction
//               mispredict_cnt     out saturating mispredict count
//
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int GHR_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PC_F,
    output logic            pred_taken_F,
    output logic [XLEN-1:0] pred_target_F,
    input  logic            upd_valid_D,
    input  logic [XLEN-1:0] upd_PC_D,
    input  logic            upd_is_branch_D,
    input  logic            upd_taken_D,
    input  logic [XLEN-1:0] upd_target_D,
    input  logic            upd_pred_taken_D,
    input  logic [XLEN-1:0] upd_pred_target_D,
    output logic            mispredict_D,
    output logic [31:0]     mispredict_cnt
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_TAG_W = XLEN - c_IDX_W - 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              r_valid   [DEPTH];
    logic [c_TAG_W-1:0] r_tag    [DEPTH];
    logic [XLEN-1:0]   r_target  [DEPTH];
    logic              r_is_jump [DEPTH];
    logic [1:0]        r_ctr     [DEPTH];
    logic [31:0]       r_mispredict_cnt;

    // ------------------------------------------------------------------
    // Index / tag extraction (instructions are word aligned, so PC[1:0]
    // carries no information)
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0] w_lookup_idx;
    logic [c_TAG_W-1:0] w_lookup_tag;
    logic [c_IDX_W-1:0] w_upd_idx;
    logic [c_TAG_W-1:0] w_upd_tag;
    logic [c_IDX_W-1:0] w_ctr_rd_idx;
    logic [c_IDX_W-1:0] w_ctr_wr_idx;
    logic [3:0]         w_unused_pc_lsbs;

    assign w_lookup_idx     = PC_F[c_IDX_W+1:2];
    assign w_lookup_tag     = PC_F[XLEN-1:c_IDX_W+2];
    assign w_upd_idx        = upd_PC_D[c_IDX_W+1:2];
    assign w_upd_tag        = upd_PC_D[XLEN-1:c_IDX_W+2];
    assign w_unused_pc_lsbs = {PC_F[1:0], upd_PC_D[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0]   r_ghr;
    logic [c_IDX_W-1:0] w_ghr_ext;

    assign w_ghr_ext    = c_IDX_W'(r_ghr);
    // Fetch and update both hash with the current history; a branch that
    // resolves in the same cycle as a lookup does not bypass into it.
    assign w_ctr_rd_idx = w_lookup_idx ^ w_ghr_ext;
    assign w_ctr_wr_idx = w_upd_idx ^ w_ghr_ext;
`else
    localparam int c_unused_ghr_w = GHR_W;

    assign w_ctr_rd_idx = w_lookup_idx;
    assign w_ctr_wr_idx = w_upd_idx;
`endif

    // ------------------------------------------------------------------
    // Lookup (combinational, reads pre-update state)
    // ------------------------------------------------------------------
    logic w_hit;

    assign w_hit = r_valid[w_lookup_idx] && (r_tag[w_lookup_idx] == w_lookup_tag);

    // Reset clears every valid bit asynchronously, so a miss (and thus
    // PC_F+4, not-taken) is what fetch sees while rst_n is low.
    assign pred_taken_F  = w_hit && (r_is_jump[w_lookup_idx] || r_ctr[w_ctr_rd_idx][1]);
    assign pred_target_F = w_hit ? r_target[w_lookup_idx] : (PC_F + XLEN'(4));

    // ------------------------------------------------------------------
    // Mispredict detection: a target difference only matters when the
    // instruction was actually taken.
    // ------------------------------------------------------------------
    assign mispredict_D = upd_valid_D &&
                          ((upd_taken_D != upd_pred_taken_D) ||
                           (upd_taken_D && (upd_target_D != upd_pred_target_D)));

    assign mispredict_cnt = r_mispredict_cnt;

    // ------------------------------------------------------------------
    // Counter next value (saturating at 2'b00 and 2'b11)
    // ------------------------------------------------------------------
    logic [1:0] w_ctr_cur;
    logic [1:0] w_ctr_next;

    assign w_ctr_cur = r_ctr[w_ctr_wr_idx];

    always_comb begin
        w_ctr_next = w_ctr_cur;
        if (upd_taken_D) begin
            if (w_ctr_cur != 2'b11) begin
                w_ctr_next = w_ctr_cur + 2'b01;
            end
        end else begin
            if (w_ctr_cur != 2'b00) begin
                w_ctr_next = w_ctr_cur - 2'b01;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reset-controlled state: valid bits, counters, history, count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
`ifdef BP_GSHARE_EN
            r_ghr <= '0;
`endif
            r_mispredict_cnt <= '0;
        end else begin
            if (upd_valid_D) begin
                // Taken transfers (re)allocate; not-taken branches never do.
                if (upd_taken_D) begin
                    r_valid[w_upd_idx] <= 1'b1;
                end
                // Jumps leave the direction counters and history alone.
                if (upd_is_branch_D) begin
                    r_ctr[w_ctr_wr_idx] <= w_ctr_next;
`ifdef BP_GSHARE_EN
                    r_ghr <= GHR_W'({r_ghr, upd_taken_D});
`endif
                end
            end
            if (mispredict_D && (r_mispredict_cnt != 32'hFFFF_FFFF)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // BTB payload: no reset needed, qualified by valid. Gated by rst_n so
    // nothing is captured at an edge where reset is still asserted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && upd_valid_D && upd_taken_D) begin
            r_tag[w_upd_idx]     <= w_upd_tag;
            r_target[w_upd_idx]  <= upd_target_D;
            r_is_jump[w_upd_idx] <= !upd_is_branch_D;
        end
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter XLEN, 32, data/address width.
REQ-002 Parameter DEPTH, 64, entries in BTB and counter table; power of two, 4..1024.
REQ-003 Parameter GHR_W, 6, global history bits; 1..log2(DEPTH).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 PC_F  in  XLEN  fetch-stage PC to predict.
REQ-007 pred_taken_F  out  1  predict redirect at fetch.
REQ-008 pred_target_F  out  XLEN  predicted target.
REQ-009 upd_valid_D  in  1  decode-stage resolved control-transfer instruction, one per cycle.
REQ-010 upd_PC_D  in  XLEN  PC of resolved instruction.
REQ-011 upd_is_branch_D  in  1  1 = conditional branch, 0 = JAL/JALR.
REQ-012 upd_taken_D  in  1  resolved direction (always 1 for jumps).
REQ-013 upd_target_D  in  XLEN  resolved target.
REQ-014 upd_pred_taken_D, upd_pred_target_D  in  1/XLEN  prediction carried from fetch with the instruction.
REQ-015 mispredict_D  out  1  resolved outcome differs from carried prediction.
REQ-016 mispredict_cnt  out  32  saturating mispredict count.

Function
REQ-017 IDX = PC[log2(DEPTH)+1:2]; TAG = PC[XLEN-1:log2(DEPTH)+2].
REQ-018 Entry: valid, tag, target, is_jump; separate 2-bit saturating counter table.
REQ-019 Lookup combinational from registered state: hit = valid && tag match at IDX(PC_F); zero-cycle latency.
REQ-020 pred_taken_F = hit && (is_jump || ctr[1]); pred_target_F = entry target on hit, else PC_F+4.
REQ-021 Update written at rising edge when upd_valid_D=1; no effect otherwise.
REQ-022 Branch update: counter +1 if taken (saturate 11), -1 if not taken (saturate 00).
REQ-023 Taken update (branch or jump): write valid=1, tag, target, is_jump=!upd_is_branch_D at IDX(upd_PC_D), replacing any alias.
REQ-024 Not-taken branch with BTB miss: no BTB allocation; counter still updated.
REQ-025 Jump update leaves counter unchanged.
REQ-026 Same-cycle lookup and update to same index: lookup returns pre-update value (no bypass).
REQ-027 mispredict_D = upd_valid_D && (upd_taken_D != upd_pred_taken_D || (upd_taken_D && upd_target_D != upd_pred_target_D)); combinational.
REQ-028 mispredict_cnt increments by 1 at clock edge when mispredict_D=1; holds at 32'hFFFFFFFF.

Reset
REQ-029 rst_n low: all valid=0, counters=2'b01, GHR=0, mispredict_cnt=0, immediately and independent of clk.
REQ-030 Outputs during reset: pred_taken_F=0, pred_target_F=PC_F+4; mispredict_D still combinational from inputs.
REQ-031 Update arriving in the cycle rst_n deasserts is applied only if rst_n is high at that rising edge.

Configuration
REQ-032 Macro BP_GSHARE_EN defined: counter index = IDX XOR zero-extended GHR; GHR shifts left inserting upd_taken_D on each branch update (not jumps); BTB still PC-indexed.
REQ-033 BP_GSHARE_EN undefined: counter index = IDX; no GHR register present.

Verification
REQ-034 After reset, PC_F=0x100 -> pred_taken_F=0, pred_target_F=0x104.
REQ-035 JAL update PC 0x200 target 0x400, then PC_F=0x200 -> pred_taken_F=1, pred_target_F=0x400 next cycle; same-cycle lookup -> 0.
REQ-036 Branch PC 0x300 taken twice (target 0x340) -> ctr 11, predict taken; three not-taken -> ctr 00, pred_taken_F=0, entry still valid.
REQ-037 DEPTH=64: taken updates at 0x1000 then 0x1100 (same IDX) -> 0x1000 misses, 0x1100 hits.
REQ-038 Update taken=1, pred_taken=1, target 0x500 vs carried 0x504 -> mispredict_D=1, mispredict_cnt 0->1; force count 0xFFFFFFFF -> stays.
REQ-039 rst_n pulsed low mid-run between clock edges -> all entries invalid and cnt=0 without clock edge; with BP_GSHARE_EN, GHR=0.
